// File: rtl/csi_dbg_pkg.sv
// ---------------------------------------------------------------------------
// csi_dbg_pkg
// Shared types and constants for the CSI-2 UART debug streamer.
//   tx_state_e    : 8N1 transmitter states (idle, start, data, stop)
//   MARK_BYTE_DEF : default frame-marker byte
//   OVF_W         : width of the saturating overflow counter
// ---------------------------------------------------------------------------
package csi_dbg_pkg;

   typedef enum logic [1:0] {
      TxIdle,
      TxStart,
      TxData,
      TxStop
   } tx_state_e;

   localparam logic [7:0]  MARK_BYTE_DEF = 8'hA5;
   localparam int unsigned OVF_W         = 16;

endpackage

// File: rtl/dbg_uart_tx.sv
// ---------------------------------------------------------------------------
// dbg_uart_tx
// 8N1 UART transmitter with a valid/ready byte input.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_valid        : byte available at i_data
//   i_data         : byte to send (LSB first)
//   o_ready        : high only in idle; a byte is taken when i_valid && o_ready
//   o_tx           : registered serial output, idle high
//   o_busy         : transmitter not idle
// ---------------------------------------------------------------------------
module dbg_uart_tx
   import csi_dbg_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_valid,
   input  logic [7:0] i_data,
   output logic       o_ready,
   output logic       o_tx,
   output logic       o_busy
);

   localparam int TimerW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TimerW-1:0] TimerLast = TimerW'(CLKS_PER_BIT - 1);

   tx_state_e         r_state, w_state_d;
   logic [TimerW-1:0] r_timer, w_timer_d;
   logic [2:0]        r_bit_idx, w_bit_idx_d;
   logic [7:0]        r_shift, w_shift_d;
   logic              r_tx, w_tx_d;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state   <= TxIdle;
         r_timer   <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_tx      <= 1'b1;
      end else begin
         r_state   <= w_state_d;
         r_timer   <= w_timer_d;
         r_bit_idx <= w_bit_idx_d;
         r_shift   <= w_shift_d;
         r_tx      <= w_tx_d;
      end
   end

   // The line level for the next cycle is computed here so o_tx comes
   // straight from a flop; the shift register always holds the current bit
   // in position 0.
   always_comb begin
      w_state_d   = r_state;
      w_timer_d   = r_timer;
      w_bit_idx_d = r_bit_idx;
      w_shift_d   = r_shift;
      w_tx_d      = r_tx;
      unique case (r_state)
         TxIdle: begin
            w_tx_d = 1'b1;
            if (i_valid) begin
               w_shift_d = i_data;
               w_timer_d = '0;
               w_tx_d    = 1'b0;
               w_state_d = TxStart;
            end
         end
         TxStart: begin
            if (r_timer == TimerLast) begin
               w_timer_d   = '0;
               w_bit_idx_d = '0;
               w_tx_d      = r_shift[0];
               w_state_d   = TxData;
            end else begin
               w_timer_d = r_timer + TimerW'(1);
            end
         end
         TxData: begin
            if (r_timer == TimerLast) begin
               w_timer_d = '0;
               if (r_bit_idx == 3'd7) begin
                  w_tx_d    = 1'b1;
                  w_state_d = TxStop;
               end else begin
                  w_bit_idx_d = r_bit_idx + 3'd1;
                  w_shift_d   = {1'b0, r_shift[7:1]};
                  w_tx_d      = r_shift[1];
               end
            end else begin
               w_timer_d = r_timer + TimerW'(1);
            end
         end
         TxStop: begin
            if (r_timer == TimerLast) begin
               w_timer_d = '0;
               w_state_d = TxIdle;
            end else begin
               w_timer_d = r_timer + TimerW'(1);
            end
         end
         default: w_state_d = TxIdle;
      endcase
   end

   assign o_ready = (r_state == TxIdle);
   assign o_busy  = (r_state != TxIdle);
   assign o_tx    = r_tx;

endmodule

// File: rtl/csi_uart_dbg.sv
// ---------------------------------------------------------------------------
// csi_uart_dbg
// Debug streamer: captures one byte lane of the CSI payload stream (with
// optional decimation), buffers it in a byte FIFO and sends it 8N1 on a UART.
// Optional feature macro: CSI_DBG_FRAME_MARK_EN (push MARK_BYTE on vsync).
//   sys_clk, sys_rst_n : clock, synchronous active-low reset
//   payload_data       : payload word
//   payload_enable     : payload word valid
//   payload_frame      : high during a long packet
//   vsync              : frame-start pulse (used only with the marker feature)
//   byte_lane          : lane select; out-of-range lanes select lane 0
//   uart_tx, uart_busy : serial output (idle high), transmitter active
//   fifo_level         : FIFO occupancy
//   ovf_count          : saturating count of dropped bytes
// ---------------------------------------------------------------------------
module csi_uart_dbg
   import csi_dbg_pkg::*;
#(
   parameter int         WORD_W       = 32,
   parameter int         FIFO_DEPTH   = 16,
   parameter int         DECIM        = 1,
   parameter int         CLKS_PER_BIT = 104,
   parameter logic [7:0] MARK_BYTE    = MARK_BYTE_DEF
) (
   input  logic                                        sys_clk,
   input  logic                                        sys_rst_n,
   input  logic [WORD_W-1:0]                           payload_data,
   input  logic                                        payload_enable,
   input  logic                                        payload_frame,
   input  logic                                        vsync,
   input  logic [((WORD_W/8 > 1) ? $clog2(WORD_W/8) : 1)-1:0] byte_lane,
   output logic                                        uart_tx,
   output logic                                        uart_busy,
   output logic [$clog2(FIFO_DEPTH):0]                 fifo_level,
   output logic [OVF_W-1:0]                            ovf_count
);

   localparam int Lanes = WORD_W / 8;
   localparam int AddrW = $clog2(FIFO_DEPTH);
   localparam int PtrW  = AddrW + 1;
   localparam int DcntW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [DcntW-1:0] DcntLast = DcntW'(DECIM - 1);

   logic             r_frame_q;
   logic [DcntW-1:0] r_dcnt, w_dcnt_eff, w_dcnt_d;
   logic             w_beat, w_capture;
   logic [7:0]       w_lane_byte, w_push_byte;
   logic             w_push_req, w_extra_drop, w_push, w_pop;
   logic             w_full, w_empty, w_tx_ready;
   logic [PtrW-1:0]  r_wptr, r_rptr;
   logic [7:0]       r_mem [FIFO_DEPTH];
   logic [OVF_W-1:0] r_ovf, w_ovf_d;
   logic [OVF_W:0]   w_ovf_sum;
   logic [1:0]       w_ndrop;

   // A rising payload_frame restarts decimation on that same cycle, so an
   // enable coinciding with the rise is always captured.
   always_comb begin
      w_dcnt_eff = (payload_frame && !r_frame_q) ? '0 : r_dcnt;
      w_beat     = payload_enable && payload_frame;
      w_capture  = w_beat && (w_dcnt_eff == '0);
      w_dcnt_d   = w_dcnt_eff;
      if (w_beat) begin
         w_dcnt_d = (w_dcnt_eff == DcntLast) ? '0 : w_dcnt_eff + DcntW'(1);
      end
   end

   always_comb begin
      w_lane_byte = payload_data[7:0];
      for (int l = 0; l < Lanes; l++) begin
         if (int'(byte_lane) == l) w_lane_byte = payload_data[8*l +: 8];
      end
   end

`ifdef CSI_DBG_FRAME_MARK_EN
   // The marker wins the single push slot; a coinciding data byte is dropped.
   assign w_push_req   = w_capture || vsync;
   assign w_push_byte  = vsync ? MARK_BYTE : w_lane_byte;
   assign w_extra_drop = w_capture && vsync;
`else
   logic w_unused_mark;
   assign w_unused_mark = vsync ^ (^MARK_BYTE);
   assign w_push_req    = w_capture;
   assign w_push_byte   = w_lane_byte;
   assign w_extra_drop  = 1'b0;
`endif

   // Full is judged on pre-pop occupancy.
   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[PtrW-1] != r_rptr[PtrW-1]) &&
                    (r_wptr[PtrW-2:0] == r_rptr[PtrW-2:0]);
   assign w_push  = w_push_req && !w_full;
   assign w_pop   = w_tx_ready && !w_empty;

   always_comb begin
      w_ndrop   = {1'b0, w_push_req && w_full} + {1'b0, w_extra_drop};
      w_ovf_sum = {1'b0, r_ovf} + (OVF_W+1)'(w_ndrop);
      w_ovf_d   = w_ovf_sum[OVF_W] ? {OVF_W{1'b1}} : w_ovf_sum[OVF_W-1:0];
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_frame_q <= 1'b0;
         r_dcnt    <= '0;
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_ovf     <= '0;
      end else begin
         r_frame_q <= payload_frame;
         r_dcnt    <= w_dcnt_d;
         r_ovf     <= w_ovf_d;
         if (w_push) r_wptr <= r_wptr + PtrW'(1);
         if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (w_push) r_mem[r_wptr[AddrW-1:0]] <= w_push_byte;
   end

   dbg_uart_tx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_tx (
      .i_clk   (sys_clk),
      .i_rst_n (sys_rst_n),
      .i_valid (!w_empty),
      .i_data  (r_mem[r_rptr[AddrW-1:0]]),
      .o_ready (w_tx_ready),
      .o_tx    (uart_tx),
      .o_busy  (uart_busy)
   );

   assign fifo_level = r_wptr - r_rptr;
   assign ovf_count  = r_ovf;

endmodule

// File: tb/tb_csi_uart_dbg.sv
// ---------------------------------------------------------------------------
// tb_csi_uart_dbg
// Directed bench for csi_uart_dbg. Instance A: 32-bit words, DECIM=1.
// Instance B: 24-bit words (lane 3 out of range), DECIM=3. Both use
// FIFO_DEPTH=4 and CLKS_PER_BIT=4 and share all inputs. A UART receiver
// per instance collects decoded bytes into a queue.
// ---------------------------------------------------------------------------
module tb_csi_uart_dbg;

   localparam int BitC = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] data;
   logic        en, frame, vsync;
   logic [1:0]  lane;
   logic        tx_a, busy_a, tx_b, busy_b;
   logic [2:0]  lvl_a, lvl_b;
   logic [15:0] ovf_a, ovf_b;

   int n_err = 0;
   int n_chk = 0;
   int n_fe  = 0;
   logic [7:0] q_a[$];
   logic [7:0] q_b[$];

   always #5 clk = ~clk;

   csi_uart_dbg #(
      .WORD_W(32), .FIFO_DEPTH(4), .DECIM(1), .CLKS_PER_BIT(BitC), .MARK_BYTE(8'hA5)
   ) dut_a (
      .sys_clk(clk), .sys_rst_n(rst_n), .payload_data(data), .payload_enable(en),
      .payload_frame(frame), .vsync(vsync), .byte_lane(lane), .uart_tx(tx_a),
      .uart_busy(busy_a), .fifo_level(lvl_a), .ovf_count(ovf_a)
   );

   csi_uart_dbg #(
      .WORD_W(24), .FIFO_DEPTH(4), .DECIM(3), .CLKS_PER_BIT(BitC), .MARK_BYTE(8'hA5)
   ) dut_b (
      .sys_clk(clk), .sys_rst_n(rst_n), .payload_data(data[23:0]), .payload_enable(en),
      .payload_frame(frame), .vsync(vsync), .byte_lane(lane), .uart_tx(tx_b),
      .uart_busy(busy_b), .fifo_level(lvl_b), .ovf_count(ovf_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic txsel(input bit sel);
      return sel ? tx_b : tx_a;
   endfunction

   function automatic logic [31:0] qget(input bit sel, input int k);
      if (sel) return (q_b.size() > k) ? 32'(q_b[k]) : 32'h1FF;
      return (q_a.size() > k) ? 32'(q_a[k]) : 32'h1FF;
   endfunction

   // Samples 1 time unit after each rising edge; centre of bit n is
   // BitC/2 + n*BitC cycles after the first low cycle of the start bit.
   task automatic rx_mon(input bit sel);
      logic [7:0] b;
      bit         ok;
      logic       v;
      int         n;
      forever begin
         @(posedge clk); #1;
         if (rst_n === 1'b1 && txsel(sel) === 1'b0) begin
            ok = 1'b1;
            b  = '0;
            for (int k = 1; k <= BitC/2 + 9*BitC; k++) begin
               @(posedge clk); #1;
               if (rst_n !== 1'b1) begin
                  ok = 1'b0;
                  break;
               end
               v = txsel(sel);
               if (k == BitC/2) begin
                  if (v !== 1'b0) begin
                     ok = 1'b0;
                     n_fe++;
                     break;
                  end
               end else if (k > BitC/2 && ((k - BitC/2) % BitC) == 0) begin
                  n = (k - BitC/2) / BitC;
                  if (n <= 8) b[n-1] = v;
                  else if (v !== 1'b1) begin
                     ok = 1'b0;
                     n_fe++;
                  end
               end
            end
            if (ok) begin
               if (sel) q_b.push_back(b);
               else q_a.push_back(b);
            end
         end
      end
   endtask

   initial rx_mon(1'b0);
   initial rx_mon(1'b1);

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      en = 1'b0; frame = 1'b0; vsync = 1'b0;
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(1);
      q_a.delete();
      q_b.delete();
   endtask

   int  peak;
   bit  seen_low;

   initial begin
      rst_n = 1'b0; data = '0; en = 1'b0; frame = 1'b0; vsync = 1'b0; lane = '0;
      step(3);
      chk("rst_tx_a", 32'(tx_a), 32'd1);
      chk("rst_busy_a", 32'(busy_a), 32'd0);
      chk("rst_lvl_a", 32'(lvl_a), 32'd0);
      chk("rst_ovf_a", 32'(ovf_a), 32'd0);
      chk("rst_tx_b", 32'(tx_b), 32'd1);
      rst_n = 1'b1;
      step(2);

      // Single byte, lane 2 of 32'h00C30000 -> 8'hC3
      frame = 1'b1; lane = 2'd2; data = 32'h00C3_0000; en = 1'b1;
      step(1);
      en = 1'b0;
      chk("sb_lvl_after_push", 32'(lvl_a), 32'd1);
      chk("sb_tx_still_idle", 32'(tx_a), 32'd1);
      step(1);
      chk("sb_start_low", 32'(tx_a), 32'd0);
      chk("sb_busy", 32'(busy_a), 32'd1);
      chk("sb_lvl_after_pop", 32'(lvl_a), 32'd0);
      step(39);
      chk("sb_stop_last_busy", 32'(busy_a), 32'd1);
      chk("sb_stop_high", 32'(tx_a), 32'd1);
      step(1);
      chk("sb_idle_after_40", 32'(busy_a), 32'd0);
      step(10);
      chk("sb_count", 32'(q_a.size()), 32'd1);
      chk("sb_byte", qget(1'b0, 0), 32'hC3);
      chk("sb_idle_high", 32'(tx_a), 32'd1);

      // Decimation on B: bytes 0..6 -> 0,3,6; frame re-rise, 7,8 -> 7
      do_reset();
      lane = 2'd0; frame = 1'b1;
      for (int i = 0; i < 7; i++) begin
         data = 32'(i); en = 1'b1;
         step(1);
      end
      en = 1'b0; frame = 1'b0;
      step(1);
      frame = 1'b1; data = 32'd7; en = 1'b1;
      step(1);
      data = 32'd8;
      step(1);
      en = 1'b0; frame = 1'b0;
      step(4 * (10 * BitC + 1) + 10);
      chk("dec_count", 32'(q_b.size()), 32'd4);
      chk("dec_b0", qget(1'b1, 0), 32'd0);
      chk("dec_b1", qget(1'b1, 1), 32'd3);
      chk("dec_b2", qget(1'b1, 2), 32'd6);
      chk("dec_b3", qget(1'b1, 3), 32'd7);
      chk("dec_ovf", 32'(ovf_b), 32'd0);
      chk("dec_lvl", 32'(lvl_b), 32'd0);

      // Lane 3: A takes data[31:24]; on B it is out of range -> lane 0
      do_reset();
      frame = 1'b1; lane = 2'd3; data = 32'h77AB_CD12; en = 1'b1;
      step(1);
      en = 1'b0; frame = 1'b0;
      step(50);
      chk("lane3_a", qget(1'b0, 0), 32'h77);
      chk("lane_oor_b", qget(1'b1, 0), 32'h12);

      // Overflow on A: TX busy with 8'h10, then 10 captures into a 4-deep FIFO
      do_reset();
      lane = 2'd0; frame = 1'b1; data = 32'h10; en = 1'b1;
      step(1);
      en = 1'b0;
      step(3);
      peak = 0;
      for (int i = 0; i < 10; i++) begin
         data = 32'h20 + 32'(i); en = 1'b1;
         step(1);
         if (int'(lvl_a) > peak) peak = int'(lvl_a);
      end
      en = 1'b0; frame = 1'b0;
      chk("ovf_peak", 32'(peak), 32'd4);
      chk("ovf_count", 32'(ovf_a), 32'd6);
      step(5 * (10 * BitC + 1) + 10);
      chk("ovf_sent", 32'(q_a.size()), 32'd5);
      chk("ovf_b0", qget(1'b0, 0), 32'h10);
      chk("ovf_b1", qget(1'b0, 1), 32'h20);
      chk("ovf_b2", qget(1'b0, 2), 32'h21);
      chk("ovf_b3", qget(1'b0, 3), 32'h22);
      chk("ovf_b4", qget(1'b0, 4), 32'h23);
      chk("ovf_lvl_drained", 32'(lvl_a), 32'd0);

      // vsync coinciding with a capture of 8'h11
      do_reset();
      lane = 2'd0; frame = 1'b1; data = 32'h11; en = 1'b1; vsync = 1'b1;
      step(1);
      en = 1'b0; vsync = 1'b0; frame = 1'b0;
      step(50);
      chk("mark_count", 32'(q_a.size()), 32'd1);
`ifdef CSI_DBG_FRAME_MARK_EN
      chk("mark_byte", qget(1'b0, 0), 32'hA5);
      chk("mark_ovf", 32'(ovf_a), 32'd1);
`else
      chk("mark_byte", qget(1'b0, 0), 32'h11);
      chk("mark_ovf", 32'(ovf_a), 32'd0);
`endif

      // Reset during data bit 3 with one byte still queued
      do_reset();
      lane = 2'd0; frame = 1'b1; data = 32'h5A; en = 1'b1;
      step(1);
      data = 32'h3C;
      step(1);
      en = 1'b0; frame = 1'b0;
      chk("rmb_start_low", 32'(tx_a), 32'd0);
      chk("rmb_lvl_pending", 32'(lvl_a), 32'd1);
      step(17);
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      chk("rmb_tx", 32'(tx_a), 32'd1);
      chk("rmb_lvl", 32'(lvl_a), 32'd0);
      chk("rmb_busy", 32'(busy_a), 32'd0);
      seen_low = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step(1);
         if (tx_a !== 1'b1) seen_low = 1'b1;
      end
      chk("rmb_no_output", 32'(seen_low), 32'd0);
      chk("rmb_no_bytes", 32'(q_a.size()), 32'd0);

      // Saturation: continuous captures on A far exceed the drain rate
      do_reset();
      lane = 2'd0; frame = 1'b1; data = 32'h42; en = 1'b1;
      step(68000);
      chk("sat_ovf", 32'(ovf_a), 32'hFFFF);
      step(50);
      chk("sat_hold", 32'(ovf_a), 32'hFFFF);
      en = 1'b0; frame = 1'b0;
      step(5 * (10 * BitC + 1));
      chk("framing_errors", 32'(n_fe), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
